// File: rtl/aurora_hls_monitor.sv
// ---------------------------------------------------------------------------
// aurora_hls_monitor
//
// Event and traffic counter block for the Aurora HLS link. It samples the
// Aurora core status vector, the RX/TX FIFO almost-full flags and the
// AXI-Stream handshakes every clock. It keeps 17 free-running cycle counters,
// one per condition. The block is purely observational and drives nothing
// back into the datapath.
//
// Build option:
//   AURORA_MONITOR_SATURATE_EN  - when defined, counters stick at all-ones
//                                 instead of wrapping to zero.
//
// Parameters:
//   COUNTER_WIDTH   width of every counter output (default 32)
//
// Ports:
//   clk                      sole clock, counters update on rising edge
//   rst                      asynchronous active-low reset, clears counters
//   aurora_status[12:0]      [12:9] gt_powergood, [8:5] line_up,
//                            [4] gt_pll_lock, [3] mmcm_not_locked,
//                            [2] hard_err, [1] soft_err, [0] channel_up
//   fifo_rx_almost_full      RX FIFO almost-full flag
//   fifo_tx_almost_full      TX FIFO almost-full flag
//   tx_tvalid / tx_tready    TX stream handshake
//   rx_tvalid                RX stream valid (no backpressure on RX)
//   *_count                  per-condition cycle counters
// ---------------------------------------------------------------------------
module aurora_hls_monitor #(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [12:0]              aurora_status,
    input  logic                     fifo_rx_almost_full,
    input  logic                     fifo_tx_almost_full,
    input  logic                     tx_tvalid,
    input  logic                     tx_tready,
    input  logic                     rx_tvalid,
    output logic [COUNTER_WIDTH-1:0] gt_not_ready_0_count,
    output logic [COUNTER_WIDTH-1:0] gt_not_ready_1_count,
    output logic [COUNTER_WIDTH-1:0] gt_not_ready_2_count,
    output logic [COUNTER_WIDTH-1:0] gt_not_ready_3_count,
    output logic [COUNTER_WIDTH-1:0] line_down_0_count,
    output logic [COUNTER_WIDTH-1:0] line_down_1_count,
    output logic [COUNTER_WIDTH-1:0] line_down_2_count,
    output logic [COUNTER_WIDTH-1:0] line_down_3_count,
    output logic [COUNTER_WIDTH-1:0] pll_not_locked_count,
    output logic [COUNTER_WIDTH-1:0] mmcm_not_locked_count,
    output logic [COUNTER_WIDTH-1:0] hard_err_count,
    output logic [COUNTER_WIDTH-1:0] soft_err_count,
    output logic [COUNTER_WIDTH-1:0] channel_down_count,
    output logic [COUNTER_WIDTH-1:0] fifo_rx_overflow_count,
    output logic [COUNTER_WIDTH-1:0] fifo_tx_overflow_count,
    output logic [COUNTER_WIDTH-1:0] tx_count,
    output logic [COUNTER_WIDTH-1:0] rx_count
);

    localparam logic [12:0] GT_POWERGOOD    = 13'h1E00;
    localparam logic [12:0] LINE_UP         = 13'h01E0;
    localparam logic [12:0] GT_PLL_LOCK     = 13'h0010;
    localparam logic [12:0] MMCM_NOT_LOCKED = 13'h0008;
    localparam logic [12:0] HARD_ERR        = 13'h0004;
    localparam logic [12:0] SOFT_ERR        = 13'h0002;
    localparam logic [12:0] CHANNEL_UP      = 13'h0001;
    localparam logic [12:0] CORE_STATUS_OK  = 13'h1FF1;

    localparam int NUM_CNT = 17;

    // XOR against the healthy pattern turns every status bit into an
    // "abnormal" flag, regardless of whether that bit is active-high or
    // active-low in the core.
    logic [12:0]        status_bad;
    logic [3:0]         gt_bad;
    logic [3:0]         line_bad;
    logic [NUM_CNT-1:0] cond;

    assign status_bad = aurora_status ^ CORE_STATUS_OK;
    assign gt_bad     = 4'((status_bad & GT_POWERGOOD) >> 9);
    assign line_bad   = 4'((status_bad & LINE_UP) >> 5);

    assign cond[3:0]  = gt_bad;
    assign cond[7:4]  = line_bad;
    assign cond[8]    = |(status_bad & GT_PLL_LOCK);
    assign cond[9]    = |(status_bad & MMCM_NOT_LOCKED);
    assign cond[10]   = |(status_bad & HARD_ERR);
    assign cond[11]   = |(status_bad & SOFT_ERR);
    assign cond[12]   = |(status_bad & CHANNEL_UP);
    assign cond[13]   = fifo_rx_almost_full;
    assign cond[14]   = fifo_tx_almost_full;
    assign cond[15]   = tx_tvalid & tx_tready;
    assign cond[16]   = rx_tvalid;

    // Next value of a counter on an increment: wraps modulo 2^W by default,
    // sticks at all-ones in the saturating build.
    function automatic logic [COUNTER_WIDTH-1:0] bump(input logic [COUNTER_WIDTH-1:0] v);
`ifdef AURORA_MONITOR_SATURATE_EN
        if (&v) begin
            return v;
        end
        return v + 1'b1;
`else
        return v + 1'b1;
`endif
    endfunction

    logic [COUNTER_WIDTH-1:0] cnt [NUM_CNT];

    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt[i] <= '0;
            end else if (cond[i]) begin
                cnt[i] <= bump(cnt[i]);
            end
        end
    end

    assign gt_not_ready_0_count   = cnt[0];
    assign gt_not_ready_1_count   = cnt[1];
    assign gt_not_ready_2_count   = cnt[2];
    assign gt_not_ready_3_count   = cnt[3];
    assign line_down_0_count      = cnt[4];
    assign line_down_1_count      = cnt[5];
    assign line_down_2_count      = cnt[6];
    assign line_down_3_count      = cnt[7];
    assign pll_not_locked_count   = cnt[8];
    assign mmcm_not_locked_count  = cnt[9];
    assign hard_err_count         = cnt[10];
    assign soft_err_count         = cnt[11];
    assign channel_down_count     = cnt[12];
    assign fifo_rx_overflow_count = cnt[13];
    assign fifo_tx_overflow_count = cnt[14];
    assign tx_count               = cnt[15];
    assign rx_count               = cnt[16];

endmodule

// File: tb/tb_aurora_hls_monitor.sv
// ---------------------------------------------------------------------------
// tb_aurora_hls_monitor
//
// Directed bench for aurora_hls_monitor. A 32-bit instance is exercised
// through every status mask, the FIFO flags, the stream handshakes and an
// asynchronous reset in mid-run. A 4-bit instance with its own reset shows
// counter wrap (or saturation when AURORA_MONITOR_SATURATE_EN is defined).
// ---------------------------------------------------------------------------
module tb_aurora_hls_monitor;

    localparam logic [12:0] GT_POWERGOOD    = 13'h1E00;
    localparam logic [12:0] LINE_UP         = 13'h01E0;
    localparam logic [12:0] GT_PLL_LOCK     = 13'h0010;
    localparam logic [12:0] MMCM_NOT_LOCKED = 13'h0008;
    localparam logic [12:0] HARD_ERR        = 13'h0004;
    localparam logic [12:0] SOFT_ERR        = 13'h0002;
    localparam logic [12:0] CHANNEL_UP      = 13'h0001;
    localparam logic [12:0] CORE_STATUS_OK  = 13'h1FF1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rst_w = 1'b0;
    logic [12:0] aurora_status = CORE_STATUS_OK;
    logic        fifo_rx_almost_full = 1'b0;
    logic        fifo_tx_almost_full = 1'b0;
    logic        tx_tvalid = 1'b0;
    logic        tx_tready = 1'b0;
    logic        rx_tvalid = 1'b0;

    logic [31:0] obs [17];
    logic [3:0]  obs_w [17];
    logic [31:0] exp_cnt [17];

    int vectors = 0;
    int miscompares = 0;

    string names [17] = '{"gt_nr0", "gt_nr1", "gt_nr2", "gt_nr3",
                          "line_dn0", "line_dn1", "line_dn2", "line_dn3",
                          "pll_nl", "mmcm_nl", "hard_err", "soft_err",
                          "chan_dn", "rx_ovf", "tx_ovf", "tx_cnt", "rx_cnt"};

    always #5 clk = ~clk;

    aurora_hls_monitor #(.COUNTER_WIDTH(32)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .aurora_status          (aurora_status),
        .fifo_rx_almost_full    (fifo_rx_almost_full),
        .fifo_tx_almost_full    (fifo_tx_almost_full),
        .tx_tvalid              (tx_tvalid),
        .tx_tready              (tx_tready),
        .rx_tvalid              (rx_tvalid),
        .gt_not_ready_0_count   (obs[0]),
        .gt_not_ready_1_count   (obs[1]),
        .gt_not_ready_2_count   (obs[2]),
        .gt_not_ready_3_count   (obs[3]),
        .line_down_0_count      (obs[4]),
        .line_down_1_count      (obs[5]),
        .line_down_2_count      (obs[6]),
        .line_down_3_count      (obs[7]),
        .pll_not_locked_count   (obs[8]),
        .mmcm_not_locked_count  (obs[9]),
        .hard_err_count         (obs[10]),
        .soft_err_count         (obs[11]),
        .channel_down_count     (obs[12]),
        .fifo_rx_overflow_count (obs[13]),
        .fifo_tx_overflow_count (obs[14]),
        .tx_count               (obs[15]),
        .rx_count               (obs[16])
    );

    aurora_hls_monitor #(.COUNTER_WIDTH(4)) dut_w (
        .clk                    (clk),
        .rst                    (rst_w),
        .aurora_status          (aurora_status),
        .fifo_rx_almost_full    (fifo_rx_almost_full),
        .fifo_tx_almost_full    (fifo_tx_almost_full),
        .tx_tvalid              (tx_tvalid),
        .tx_tready              (tx_tready),
        .rx_tvalid              (rx_tvalid),
        .gt_not_ready_0_count   (obs_w[0]),
        .gt_not_ready_1_count   (obs_w[1]),
        .gt_not_ready_2_count   (obs_w[2]),
        .gt_not_ready_3_count   (obs_w[3]),
        .line_down_0_count      (obs_w[4]),
        .line_down_1_count      (obs_w[5]),
        .line_down_2_count      (obs_w[6]),
        .line_down_3_count      (obs_w[7]),
        .pll_not_locked_count   (obs_w[8]),
        .mmcm_not_locked_count  (obs_w[9]),
        .hard_err_count         (obs_w[10]),
        .soft_err_count         (obs_w[11]),
        .channel_down_count     (obs_w[12]),
        .fifo_rx_overflow_count (obs_w[13]),
        .fifo_tx_overflow_count (obs_w[14]),
        .tx_count               (obs_w[15]),
        .rx_count               (obs_w[16])
    );

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    task automatic chk_all(input string phase);
        for (int i = 0; i < 17; i++) begin
            chk_val({phase, ".", names[i]}, obs[i], exp_cnt[i]);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold a status pattern for n edges, then return to the healthy pattern.
    task automatic status_pulse(input logic [12:0] s, input int n);
        aurora_status = s;
        step(n);
        aurora_status = CORE_STATUS_OK;
    endtask

    initial begin
        for (int i = 0; i < 17; i++) exp_cnt[i] = 32'd0;

        // Reset held low for two clocks with a healthy core
        step(2);
        chk_all("reset");
        rst = 1'b1;

        // Powergood lanes down for 3 clocks
        status_pulse(CORE_STATUS_OK & ~GT_POWERGOOD, 3);
        for (int i = 0; i < 4; i++) exp_cnt[i] = 32'd3;
        chk_all("powergood");

        status_pulse(CORE_STATUS_OK & ~LINE_UP, 3);
        for (int i = 4; i < 8; i++) exp_cnt[i] = 32'd3;
        chk_all("line_up");

        status_pulse(CORE_STATUS_OK & ~GT_PLL_LOCK, 3);
        exp_cnt[8] = 32'd3;
        chk_all("pll");

        status_pulse(CORE_STATUS_OK | MMCM_NOT_LOCKED, 3);
        exp_cnt[9] = 32'd3;
        chk_all("mmcm");

        status_pulse(CORE_STATUS_OK | HARD_ERR, 3);
        exp_cnt[10] = 32'd3;
        chk_all("hard");

        status_pulse(CORE_STATUS_OK | SOFT_ERR, 3);
        exp_cnt[11] = 32'd3;
        chk_all("soft");

        status_pulse(CORE_STATUS_OK & ~CHANNEL_UP, 3);
        exp_cnt[12] = 32'd3;
        chk_all("chan");

        // Single lane only: lane 2 powergood (bit 11), lane 1 line_up (bit 6)
        status_pulse(CORE_STATUS_OK & ~13'h0840, 2);
        exp_cnt[2] = 32'd5;
        exp_cnt[5] = 32'd5;
        chk_all("lane_sel");

        // Everything low at once: all active-low conditions count together
        status_pulse(13'h0000, 2);
        for (int i = 0; i < 9; i++) exp_cnt[i] += 32'd2;
        exp_cnt[12] += 32'd2;
        chk_all("all_low");

        // Everything high: only the active-high error conditions count
        status_pulse(13'h1FFF, 1);
        exp_cnt[9]  += 32'd1;
        exp_cnt[10] += 32'd1;
        exp_cnt[11] += 32'd1;
        chk_all("all_high");

        // FIFO flags: two RX pulses, three TX pulses
        for (int k = 0; k < 2; k++) begin
            fifo_rx_almost_full = 1'b1; step(1);
            fifo_rx_almost_full = 1'b0; step(1);
        end
        for (int k = 0; k < 3; k++) begin
            fifo_tx_almost_full = 1'b1; step(1);
            fifo_tx_almost_full = 1'b0; step(1);
        end
        exp_cnt[13] = 32'd2;
        exp_cnt[14] = 32'd3;
        chk_all("fifo");

        // Handshakes: 3 full TX beats with RX, then RX alone for 2
        tx_tvalid = 1'b1; tx_tready = 1'b1; rx_tvalid = 1'b1;
        step(3);
        tx_tvalid = 1'b0;
        step(2);
        rx_tvalid = 1'b0; tx_tready = 1'b0;
        exp_cnt[15] = 32'd3;
        exp_cnt[16] = 32'd5;
        chk_all("hs");

        // tvalid without tready never counts
        tx_tvalid = 1'b1;
        step(4);
        tx_tvalid = 1'b0;
        chk_all("no_ready");

        // Asynchronous reset between edges
        aurora_status = CORE_STATUS_OK & ~CHANNEL_UP;
        step(1);
        exp_cnt[12] += 32'd1;
        chk_all("pre_areset");
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 17; i++) exp_cnt[i] = 32'd0;
        chk_all("areset");
        step(1);
        chk_all("areset_hold");
        rst = 1'b1;
        step(2);
        exp_cnt[12] = 32'd2;
        aurora_status = CORE_STATUS_OK;
        chk_all("post_areset");

        // Wrap on the 4-bit instance, soft_err held
        rst_w = 1'b1;
        aurora_status = CORE_STATUS_OK | SOFT_ERR;
        step(15);
        chk_val("w.soft_15", {28'd0, obs_w[11]}, 32'd15);
        chk_val("w.hard_idle", {28'd0, obs_w[10]}, 32'd0);
        step(1);
`ifdef AURORA_MONITOR_SATURATE_EN
        chk_val("w.soft_sat", {28'd0, obs_w[11]}, 32'd15);
        step(1);
        chk_val("w.soft_sat2", {28'd0, obs_w[11]}, 32'd15);
`else
        chk_val("w.soft_wrap", {28'd0, obs_w[11]}, 32'd0);
        step(1);
        chk_val("w.soft_after", {28'd0, obs_w[11]}, 32'd1);
`endif
        aurora_status = CORE_STATUS_OK;
        exp_cnt[11] = 32'd17;
        chk_all("wide_soft");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aurora_hls_monitor.md
Name: aurora_hls_monitor

Overview:
Event and traffic counter block for the Aurora HLS link.
- Samples the 13-bit Aurora core status vector, the RX/TX FIFO almost-full flags and the AXI-Stream handshakes every clock.
- Keeps 17 free-running per-condition cycle counters.
- Exposes the counters as plain register outputs for host readout (e.g. through an AXI-Lite register file in the enclosing kernel).
- Purely observational; it drives nothing back into the datapath.

Parameters:
- COUNTER_WIDTH, 32, width of every counter output. All ports below are listed at the default of 32.

Ports:
- clk  in  1  sole clock; all counters update on its rising edge.
- rst  in  1  asynchronous, active-low reset; clears all counters.
- aurora_status  in  13  core status: [12:9] gt_powergood[3:0], [8:5] line_up[3:0], [4] gt_pll_lock, [3] mmcm_not_locked, [2] hard_err, [1] soft_err, [0] channel_up.
- fifo_rx_almost_full  in  1  RX FIFO almost-full flag.
- fifo_tx_almost_full  in  1  TX FIFO almost-full flag.
- tx_tvalid  in  1  TX stream valid.
- tx_tready  in  1  TX stream ready.
- rx_tvalid  in  1  RX stream valid (the RX side has no backpressure).
- gt_not_ready_0_count .. gt_not_ready_3_count  out  32 each  cycles with gt_powergood[i]=0.
- line_down_0_count .. line_down_3_count  out  32 each  cycles with line_up[i]=0.
- pll_not_locked_count  out  32  cycles with gt_pll_lock=0.
- mmcm_not_locked_count  out  32  cycles with mmcm_not_locked=1.
- hard_err_count  out  32  cycles with hard_err=1.
- soft_err_count  out  32  cycles with soft_err=1.
- channel_down_count  out  32  cycles with channel_up=0.
- fifo_rx_overflow_count  out  32  cycles with fifo_rx_almost_full=1.
- fifo_tx_overflow_count  out  32  cycles with fifo_tx_almost_full=1.
- tx_count  out  32  cycles with tx_tvalid&tx_tready=1.
- rx_count  out  32  cycles with rx_tvalid=1.

Behaviour:
- Required localparams, 13-bit masks, referenced by benches:
  - GT_POWERGOOD=13'h1E00, LINE_UP=13'h01E0, GT_PLL_LOCK=13'h0010, MMCM_NOT_LOCKED=13'h0008.
  - HARD_ERR=13'h0004, SOFT_ERR=13'h0002, CHANNEL_UP=13'h0001.
  - CORE_STATUS_OK=13'h1FF1: all powergood, line_up, pll_lock and channel_up high; mmcm_not_locked, hard_err and soft_err low.
- Reset: rst low forces every counter to 0 immediately (asynchronously). Counting resumes on the first rising clk edge after rst deasserts.
- Counting: each counter adds 1 on every rising edge where its condition is true at that edge.
  - Conditions are level-sensitive, not edge-detected; an N-cycle assertion adds N.
  - Inputs are used directly, with no input register stage. A condition present before edge k is reflected in the output after edge k (1-cycle latency).
- Counters are fully independent. Any number of conditions may be true in the same cycle, and every affected counter increments.
- The per-lane counters (gt_not_ready_i, line_down_i) index by lane bit only: lane 0 = status bit 9 for powergood and bit 5 for line_up.
- With status = CORE_STATUS_OK, FIFOs not almost-full and no handshakes, all counters hold their values.
- tx_count needs tvalid and tready in the same cycle; tvalid without tready does not count. rx_count counts rx_tvalid alone.
- Overflow: a counter at 0xFFFFFFFF wraps to 0 on its next increment (modulo 2^COUNTER_WIDTH), unless the optional feature below is enabled.
- There is no synchronous clear; only rst clears the counters.

Optional Feature:
- Macro: AURORA_MONITOR_SATURATE_EN.
- Defined: every counter saturates at all-ones (0xFFFFFFFF) and holds there until rst.
- Undefined: counters wrap to 0 as described above.
- Reset and counting latency are identical in both builds.

Test Plan:
- Reset check: hold rst=0 for 2 clocks with status=CORE_STATUS_OK → all 17 outputs read 0.
- Status counters: after release, clear the GT_POWERGOOD bits for 3 clocks → gt_not_ready_0..3 = 3 each.
  - Repeat the same 3-clock toggle of each mask from CORE_STATUS_OK: LINE_UP → line_down_0..3 = 3; GT_PLL_LOCK → pll_not_locked = 3; MMCM_NOT_LOCKED, HARD_ERR, SOFT_ERR, CHANNEL_UP → each respective counter = 3.
  - Every counter not toggled stays unchanged.
- FIFO flags: pulse fifo_rx_almost_full 1 cycle on / 1 off, twice → fifo_rx_overflow_count=2. Three such pulses on the TX flag → fifo_tx_overflow_count=3.
- Handshakes: tx_tvalid=tx_tready=rx_tvalid=1 for 3 clocks, then drop tx_tvalid and keep rx_tvalid 2 more clocks → tx_count=3, rx_count=5.
  - tx_tvalid=1 with tx_tready=0 for 4 clocks → tx_count unchanged.
- Async reset mid-run: assert rst low between edges with nonzero counters → outputs 0 before the next clk edge.
- Overflow: force a counter to 0xFFFFFFFF with its condition held → next edge reads 0. With AURORA_MONITOR_SATURATE_EN defined it stays 0xFFFFFFFF.
